inst_stream_loader: RTL

Boot-time instruction loader that feeds the instruction memory read by the processor's decode path. It receives a byte stream over a valid/ready handshake (e.g. from a UART receiver), assembles 32-bit little-endian instruction words, and checks each word's 7-bit decode field `{opcode, dir_mode, inst_type}` against the legal instruction set. Legal words are written to sequential instruction-memory addresses. The processor is held in reset until a full program has loaded.

---
 rtl/loader_pkg.sv | 68 ++++++
 rtl/inst_legality_check.sv | 16 +
 rtl/inst_stream_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// loader_pkg : shared types, decode-field layout and legal instruction codes
// Rev 1.0
// ----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_LENGTH  = 2'b10;

  localparam int INST_TYPE_LSB = 0;
  localparam int INST_TYPE_W   = 2;
  localparam int DIR_MODE_LSB  = 2;
  localparam int DIR_MODE_W    = 2;
  localparam int OPCODE_LSB    = 4;
  localparam int OPCODE_W      = 3;
  localparam int FIELD_W       = OPCODE_W + DIR_MODE_W + INST_TYPE_W;

  // Register ALU
  localparam logic [6:0] CODE_RALU_0 = 7'h00;
  localparam logic [6:0] CODE_RALU_1 = 7'h10;
  localparam logic [6:0] CODE_RALU_2 = 7'h20;
  localparam logic [6:0] CODE_RALU_3 = 7'h30;
  localparam logic [6:0] CODE_RALU_4 = 7'h40;
  // Immediate ALU
  localparam logic [6:0] CODE_IALU_0 = 7'h04;
  localparam logic [6:0] CODE_IALU_1 = 7'h14;
  localparam logic [6:0] CODE_IALU_2 = 7'h24;
  // Memory
  localparam logic [6:0] CODE_MEM_0  = 7'h05;
  localparam logic [6:0] CODE_MEM_1  = 7'h15;
  localparam logic [6:0] CODE_MEM_2  = 7'h25;
  localparam logic [6:0] CODE_MEM_3  = 7'h35;
  // Jump / branch
  localparam logic [6:0] CODE_JMP_0  = 7'h06;
  localparam logic [6:0] CODE_JMP_1  = 7'h16;
  localparam logic [6:0] CODE_JMP_2  = 7'h26;
  localparam logic [6:0] CODE_JMP_3  = 7'h36;
  localparam logic [6:0] CODE_JMP_4  = 7'h46;
  localparam logic [6:0] CODE_LUI    = 7'h08;
  localparam logic [6:0] CODE_JAL    = 7'h1A;

  function automatic logic is_legal_inst(input logic [6:0] field);
    logic legal;
    case (field)
      CODE_RALU_0, CODE_RALU_1, CODE_RALU_2, CODE_RALU_3, CODE_RALU_4,
      CODE_IALU_0, CODE_IALU_1, CODE_IALU_2,
      CODE_MEM_0,  CODE_MEM_1,  CODE_MEM_2,  CODE_MEM_3,
      CODE_JMP_0,  CODE_JMP_1,  CODE_JMP_2,  CODE_JMP_3,  CODE_JMP_4,
      CODE_LUI,    CODE_JAL:  legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_legality_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_legality_check : combinational legal-code lookup on the 7-bit decode field
// Rev 1.0
// ----------------------------------------------------------------------------
module inst_legality_check
  import loader_pkg::*;
(
  input  logic [FIELD_W-1:0] decode_field,
  output logic               legal
);

  assign legal = is_legal_inst(decode_field);

endmodule
`default_nettype wire

// File: rtl/inst_stream_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_stream_loader : assembles a length-prefixed byte stream into checked
// instruction words and writes them to instruction memory.   Rev 1.0
// ----------------------------------------------------------------------------
module inst_stream_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned CAPACITY  = 2 ** ADDR_WIDTH;
  localparam logic [16:0] MAX_WORDS = 17'(CAPACITY);

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
  logic [1:0]            err_code_q, err_code_d;

  logic [FIELD_W-1:0]    decode_field;
  logic                  field_legal;
  logic                  accept;
  logic [15:0]           len_full;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  last_word;

  // Byte 0 is always in place by the time the 4th byte arrives, so the
  // decode field can be checked from the partially assembled word.
  assign decode_field = {word_q[OPCODE_LSB +: OPCODE_W],
                         word_q[DIR_MODE_LSB +: DIR_MODE_W],
                         word_q[INST_TYPE_LSB +: INST_TYPE_W]};

  inst_legality_check u_legality (
    .decode_field (decode_field),
    .legal        (field_legal)
  );

  assign accept     = in_valid && in_ready;
  assign len_full   = {in_data, len_q[7:0]};
  assign next_count = words_loaded_q + (ADDR_WIDTH+1)'(1);
  assign last_word  = (17'(next_count) == {1'b0, len_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      word_q         <= '0;
      words_loaded_q <= '0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      words_loaded_q <= words_loaded_d;
      err_code_q     <= err_code_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    words_loaded_d = words_loaded_q;
    err_code_d     = err_code_q;

    if (start) begin
      state_d        = ST_LEN0;
      byte_cnt_d     = '0;
      word_d         = '0;
      words_loaded_d = '0;
      err_code_d     = ERR_NONE;
    end else begin
      case (state_q)
        ST_LEN0: begin
          if (accept) begin
            len_d[7:0] = in_data;
            state_d    = ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (accept) begin
            len_d[15:8] = in_data;
            if (len_full == 16'd0) begin
              state_d = ST_DONE;
            end else if ({1'b0, len_full} > MAX_WORDS) begin
              state_d    = ST_ERROR;
              err_code_d = ERR_LENGTH;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (field_legal) begin
                state_d = ST_WRITE;
              end else begin
                state_d    = ST_ERROR;
                err_code_d = ERR_ILLEGAL;
              end
            end
          end
        end
        ST_WRITE: begin
          words_loaded_d = next_count;
          state_d        = last_word ? ST_DONE : ST_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      ST_LEN0, ST_LEN1, ST_DATA: in_ready = !start;
      ST_WRITE:                  mem_we   = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERROR:                  error    = 1'b1;
      default: ;
    endcase
  end

  // Address is the running count, so the write for word i lands at i.
  assign mem_addr     = words_loaded_q[ADDR_WIDTH-1:0];
  assign mem_wdata    = word_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire
